div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 restoring divider for the RV64M division instructions DIV, DIVU, REM and REMU. It sits in the execute stage beside the ALU. Its result is one of the three inputs to the result-select 3-to-1 mux, which also takes the ALU result and the memory read data. The control unit stalls on `o_busy` and advances on `o_done`.

## Interface
- `DATA_WIDTH`, 64, operand and result width in bits; must be even and at least 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `i_rstn`  in  1  reset, synchronous and active-low.
- `i_start`  in  1  request a division; sampled only in IDLE.
- `i_op`  in  2  operation: 2'd0 DIV, 2'd1 DIVU, 2'd2 REM, 2'd3 REMU.
- `i_dividend`  in  DATA_WIDTH  dividend, sampled with `i_start`.
- `i_divisor`  in  DATA_WIDTH  divisor, sampled with `i_start`.
- `o_busy`  out  1  high while an accepted operation has not yet completed.
- `o_done`  out  1  one-cycle completion pulse.
- `o_result`  out  DATA_WIDTH  quotient or remainder; valid from the `o_done` cycle until the next accepted start.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - If `i_start` = 1, latch `i_op` and both operands.
  - Divisor = 0 or signed overflow: go to DONE.
  - Otherwise: go to CALC with the iteration counter = DATA_WIDTH − 1.
- **CALC**
  - Each cycle does one restoring step: shift {remainder, quotient} left by 1, subtract the divisor magnitude, keep the difference if it is non-negative, and set the quotient LSB to 1 in that case.
  - The counter decrements each step; on counter = 0, go to DONE.
- **DONE**
  - Drive the final result and assert `o_done`; go to IDLE unconditionally.
- **Signed ops** (DIV, REM)
  - Operate on magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Negation is two's complement, truncated to DATA_WIDTH.
- **Special cases**, resolved in IDLE without iterating:
  - Divisor = 0: quotient = all ones; remainder = dividend.
  - DIV/REM with dividend = most-negative and divisor = −1: quotient = dividend; remainder = 0.
- **Start handling**
  - `i_start` in CALC or DONE is ignored; it is not queued.
  - Operand changes after acceptance have no effect.
- **Reset**
  - Reset (including mid-CALC) forces IDLE.
  - `o_busy` = 0, `o_done` = 0, `o_result` = 0; internal registers cleared.
  - Any in-flight operation is discarded.

## Timing
- Start is accepted at rising edge E0 (IDLE, `i_start` = 1).
- **Normal path**
  - `o_busy` = 1 for the cycles after E0 through edge E(DATA_WIDTH).
  - `o_done` = 1 in the cycle after edge E(DATA_WIDTH), with `o_busy` = 0.
  - Latency from accept to done = DATA_WIDTH + 1 cycles (65 at default).
- **Special path**
  - `o_done` = 1 in the cycle after E1; `o_busy` = 1 for one cycle.
- **Back-to-back**
  - The earliest next accept is the edge ending the first IDLE cycle after DONE.
  - Throughput = one op per DATA_WIDTH + 2 cycles.
- `o_result` is registered and holds its value through IDLE until the next accepted start. At that edge it is cleared to 0 and stays 0 until the next DONE.
- No combinational path from inputs to outputs.

## Structure
- Shared package `div_pkg`:
  - `t_div_op` enum (DIV, DIVU, REM, REMU).
  - `t_div_state` enum (IDLE, CALC, DONE).
- Counter width is `$clog2(DATA_WIDTH)`, declared as a localparam in the module.
- No sub-module; the restoring step stays inline in the datapath `always_ff`, and the FSM stays in the same module.

## Test plan
- DIVU 100 / 7: `o_done` exactly 65 cycles after accept; `o_result` = 14. REMU 100 / 7 gives 2.
- DIV −7 / 2 gives −3; REM −7 / 2 gives −1. DIV 7 / −2 gives −3; REM 7 / −2 gives 1.
- Divide by zero, DIVU 5 / 0: `o_result` = 0xFFFF_FFFF_FFFF_FFFF; REMU 5 / 0 gives 5; `o_done` 2 cycles after accept.
- Overflow, DIV 0x8000_0000_0000_0000 / −1: result 0x8000_0000_0000_0000; REM gives 0; 2-cycle latency.
- Hold `i_start` high throughout and change operands mid-CALC:
  - The first result is unaffected.
  - The second op is accepted only after the DONE→IDLE cycle.
- Deassert `i_rstn` for one edge at iteration 30:
  - The next cycle shows `o_busy` = 0, `o_done` = 0, `o_result` = 0.
  - A fresh DIVU 9 / 3 then returns 3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the RV64M iterative divider.
// Provides the operation and FSM state enums plus small op-decode helpers.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } t_div_op;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } t_div_state;

    // DIV and REM treat operands as two's complement.
    function automatic logic op_is_signed(input t_div_op op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder rather than the quotient.
    function automatic logic op_is_rem(input t_div_op op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk, i_rstn (sync, active-low), i_start, i_op, i_dividend,
//        i_divisor -> o_busy, o_done (1-cycle pulse), o_result (registered).
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    t_div_state            r_state;
    t_div_op               r_op;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quot;
    logic [DATA_WIDTH-1:0] r_dvsr;
    logic [DATA_WIDTH-1:0] r_pend;
    logic [DATA_WIDTH-1:0] r_result;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_done;

    // Operand decode, used only on the accepting edge.
    t_div_op               w_op;
    logic                  w_sgn;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_div0;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_spec_res;

    assign w_op    = t_div_op'(i_op);
    assign w_sgn   = op_is_signed(w_op);
    assign w_a_neg = w_sgn & i_dividend[DATA_WIDTH-1];
    assign w_b_neg = w_sgn & i_divisor[DATA_WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_mag = w_b_neg ? -i_divisor  : i_divisor;
    assign w_div0  = (i_divisor == '0);
    assign w_ovf   = w_sgn & (i_dividend == MOST_NEG) & (i_divisor == '1);

    always_comb begin
        w_spec_res = '0;
        if (w_div0) begin
            w_spec_res = op_is_rem(w_op) ? i_dividend : '1;
        end else begin
            w_spec_res = op_is_rem(w_op) ? '0 : i_dividend;
        end
    end

    // One restoring step. The partial remainder stays below the divisor,
    // so bit DATA_WIDTH of the difference is a pure borrow flag.
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_rem_nx;
    logic [DATA_WIDTH-1:0] w_quot_nx;
    logic [DATA_WIDTH-1:0] w_q_fin;
    logic [DATA_WIDTH-1:0] w_r_fin;
    logic [DATA_WIDTH-1:0] w_fin;

    assign w_shift   = {r_rem, r_quot[DATA_WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_ge      = ~w_diff[DATA_WIDTH];
    assign w_rem_nx  = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_quot_nx = {r_quot[DATA_WIDTH-2:0], w_ge};
    assign w_q_fin   = r_neg_q ? -w_quot_nx : w_quot_nx;
    assign w_r_fin   = r_neg_r ? -w_rem_nx  : w_rem_nx;
    assign w_fin     = op_is_rem(r_op) ? w_r_fin : w_q_fin;

    // Normal path finishes on the last step, so DONE already carries
    // o_done. The special path enters DONE with o_done low and raises
    // it on the way back to IDLE; in both cases the pulse is one cycle.
    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_op     <= OP_DIV;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_pend   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_op     <= w_op;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_rem    <= '0;
                        r_quot   <= w_a_mag;
                        r_dvsr   <= w_b_mag;
                        r_pend   <= w_spec_res;
                        r_cnt    <= CW'(DATA_WIDTH - 1);
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= w_quot_nx;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state  <= S_DONE;
                        r_result <= w_fin;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= ~r_done;
                    if (!r_done) begin
                        r_result <= r_pend;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV64M division vectors.
// Stimulus pushes expected result/done-cycle; a monitor pops on o_done.
module tb_div_unit;

    localparam int W = 64;

    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] MNEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
    localparam logic [W-1:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [W-1:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .i_rstn     (rstn),
        .i_start    (start),
        .i_op       (op),
        .i_dividend (a),
        .i_divisor  (b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  at;
        string        tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done at cycle %0d want none",
                         cyc);
            end else begin
                e = sbq.pop_front();
                check({e.tag, "_res"}, o_result, e.res);
                check({e.tag, "_cyc"}, W'(cyc), W'(e.at));
            end
        end
    end

    task automatic expect_push(input string tag, input logic [W-1:0] r,
                               input int unsigned at);
        exp_t e;
        e.res = r;
        e.at  = at;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (o_done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (o_done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done want done", tag);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((o_busy || o_done) && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    // lat = edges from accept to the edge that raises o_done.
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input int unsigned lat);
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_push(tag, r, cyc + lat);
        check({tag, "_busy"}, W'(o_busy), W'(1'b1));
        check({tag, "_clr"}, o_result, '0);
        wait_done(tag);
        @(negedge clk);
        check({tag, "_hold"}, o_result, r);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned c0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", W'(o_busy), '0);
        check("rst_done", W'(o_done), '0);
        check("rst_res", o_result, '0);
        rstn = 1'b1;

        do_op("divu_100_7", 2'd1, 64'd100, 64'd7, 64'd14, W);
        do_op("remu_100_7", 2'd3, 64'd100, 64'd7, 64'd2, W);
        do_op("div_m7_2",   2'd0, M7, 64'd2, M3, W);
        do_op("rem_m7_2",   2'd2, M7, 64'd2, ONES, W);
        do_op("div_7_m2",   2'd0, 64'd7, M2, M3, W);
        do_op("rem_7_m2",   2'd2, 64'd7, M2, 64'd1, W);
        do_op("divu_5_0",   2'd1, 64'd5, 64'd0, ONES, 1);
        do_op("remu_5_0",   2'd3, 64'd5, 64'd0, 64'd5, 1);
        do_op("div_ovf",    2'd0, MNEG, ONES, MNEG, 1);
        do_op("rem_ovf",    2'd2, MNEG, ONES, 64'd0, 1);
        do_op("div_m7_0",   2'd0, M7, 64'd0, ONES, 1);
        do_op("rem_m7_0",   2'd2, M7, 64'd0, M7, 1);
        do_op("divu_max",   2'd1, ONES, ONES, 64'd1, W);
        do_op("remu_max_3", 2'd3, ONES, 64'd3, 64'd0, W);
        do_op("div_min_1",  2'd0, MNEG, 64'd1, MNEG, W);
        do_op("divu_min",   2'd1, MNEG, ONES, 64'd0, W);
        do_op("remu_min",   2'd3, MNEG, ONES, MNEG, W);

        // Start held high; operands change mid-CALC.
        wait_idle();
        start = 1'b1;
        op    = 2'd1;
        a     = 64'd100;
        b     = 64'd7;
        @(posedge clk);
        #1;
        c0 = cyc;
        expect_push("hold_first", 64'd14, c0 + W);
        expect_push("hold_second", 64'd10, c0 + W + 2 + W);
        repeat (20) @(negedge clk);
        a = 64'd50;
        b = 64'd5;
        wait_done("hold_first");
        wait_done("hold_second");
        start = 1'b0;

        // Reset in the middle of an iteration.
        do_op("pre_rst", 2'd1, 64'd40, 64'd8, 64'd5, W);
        wait_idle();
        start = 1'b1;
        op    = 2'd1;
        a     = ONES;
        b     = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", W'(o_busy), '0);
        check("mid_rst_done", W'(o_done), '0);
        check("mid_rst_res", o_result, '0);

        do_op("divu_9_3", 2'd1, 64'd9, 64'd3, 64'd3, W);
        repeat (80) @(negedge clk);

        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
